// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate with bias, ReLU, rescale and saturation
module neuron_mac #(
    parameter int data_size   = 16,
    parameter int frac_bits   = 8,
    parameter int num_weights = 4,
    parameter int addr_size   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [data_size-1:0] in_data,
    output logic                 in_ready,
    output logic [addr_size-1:0] r_addr,
    output logic                 r_en,
    input  logic [data_size-1:0] weight_in,
    input  logic [data_size-1:0] bias,
    output logic                 out_valid,
    output logic [data_size-1:0] out_data,
    output logic                 busy
);

    // 8 guard bits keep up to 256 full-width products from overflowing
    localparam int acc_w = 2 * data_size + 8;
    // wide enough to index 256 inputs and to hold the terminal compare value
    localparam int cnt_w = 9;

    localparam logic signed [acc_w-1:0] sat_max =
        {{(acc_w - data_size + 1){1'b0}}, {(data_size - 1){1'b1}}};
    localparam logic [cnt_w-1:0] last_idx = cnt_w'(num_weights - 1);

    typedef enum logic [1:0] {ACCUM, WAIT, BIAS, OUT} state_t;

    state_t                       state;
    logic        [cnt_w-1:0]      count;
    logic signed [data_size-1:0]  in_d;
    logic                         mul_v;
    logic signed [acc_w-1:0]      acc;

    logic                         accept;
    logic                         last_in;
    logic signed [2*data_size-1:0] prod;
    logic signed [acc_w-1:0]      prod_ext;
    logic signed [acc_w-1:0]      bias_ext;
    logic signed [acc_w-1:0]      sum;
    logic signed [acc_w-1:0]      shifted;
    logic        [data_size-1:0]  act_val;

    assign in_ready = (state == ACCUM) || (state == OUT);
    assign accept   = in_valid && in_ready;
    assign r_en     = accept;
    assign r_addr   = addr_size'(count);
    assign busy     = (count != '0) || (state != ACCUM);
    assign last_in  = (count == last_idx);

    // weight_in arrives one cycle after its read, lining up with the registered in_d
    assign prod     = in_d * $signed(weight_in);
    assign prod_ext = {{(acc_w - 2*data_size){prod[2*data_size-1]}}, prod};
    assign bias_ext = $signed({{(acc_w - data_size){bias[data_size-1]}}, bias}) <<< frac_bits;
    assign sum      = acc + bias_ext;
    assign shifted  = sum >>> frac_bits;

    // ReLU, then floor rescale to the output format with positive saturation
    always_comb begin
        act_val = '0;
        if (sum[acc_w-1]) begin
            act_val = '0;
        end else if (shifted > sat_max) begin
            act_val = sat_max[data_size-1:0];
        end else begin
            act_val = shifted[data_size-1:0];
        end
    end

    // sequencing FSM, input capture, accumulator and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            count     <= '0;
            in_d      <= '0;
            mul_v     <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            mul_v     <= accept;
            out_valid <= 1'b0;
            if (accept) begin
                in_d <= $signed(in_data);
            end
            if (mul_v) begin
                acc <= acc + prod_ext;
            end

            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (last_in) begin
                            count <= '0;
                            state <= WAIT;
                        end else begin
                            count <= count + cnt_w'(1);
                        end
                    end
                end
                WAIT: begin
                    // the final product lands in acc during this cycle
                    state <= BIAS;
                end
                BIAS: begin
                    out_data  <= act_val;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // no product is pending here, so clearing acc loses nothing;
                    // an input accepted now is accumulated onto the cleared acc
                    acc <= '0;
                    if (accept && last_in) begin
                        count <= '0;
                        state <= WAIT;
                    end else begin
                        if (accept) begin
                            count <= count + cnt_w'(1);
                        end
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - scoreboard bench for neuron_mac
module tb_neuron_mac;

    localparam int data_size   = 16;
    localparam int frac_bits   = 8;
    localparam int num_weights = 4;
    localparam int addr_size   = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [data_size-1:0] in_data;
    logic                 in_ready;
    logic [addr_size-1:0] r_addr;
    logic                 r_en;
    logic [data_size-1:0] weight_in;
    logic [data_size-1:0] bias;
    logic                 out_valid;
    logic [data_size-1:0] out_data;
    logic                 busy;

    neuron_mac #(
        .data_size  (data_size),
        .frac_bits  (frac_bits),
        .num_weights(num_weights),
        .addr_size  (addr_size)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .r_addr   (r_addr),
        .r_en     (r_en),
        .weight_in(weight_in),
        .bias     (bias),
        .out_valid(out_valid),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [data_size-1:0] wrom [0:(1<<addr_size)-1];
    always @(posedge clk) begin
        if (r_en) weight_in <= wrom[r_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int data;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_data", out_data, e.data);
                check("out_latency", cyc, e.cyc);
            end
        end
    end

    int vd[4];
    int vw[4];

    function automatic int act_model(input longint s);
        longint q;
        if (s < 0) return 0;
        q = s / (longint'(1) << frac_bits);
        if (q > 32767) return 32767;
        return int'(q);
    endfunction

    // present n inputs of vd with weights vw; pushes the expectation when n == 4
    task automatic send_vec(input int n, input int b, input int exp_v, input int gap_max);
        bias = data_size'(b);
        for (int i = 0; i < num_weights; i++) wrom[i] = data_size'(vw[i]);
        for (int i = 0; i < n; i++) begin
            int tries;
            if (gap_max > 0) begin
                int gaps;
                gaps = $urandom_range(1, gap_max);
                for (int g = 0; g < gaps; g++) begin
                    in_valid = 1'b0;
                    #1 check("r_en_gap", r_en, 0);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = data_size'(vd[i]);
            #1;
            tries = 0;
            while (!in_ready && tries < 20) begin
                check("r_en_not_ready", r_en, 0);
                @(negedge clk);
                #1;
                tries++;
            end
            if (!in_ready) check("accept_timeout", 0, 1);
            check("r_en", r_en, 1);
            check("r_addr", r_addr, i);
            if (i == num_weights - 1) begin
                exp_t e;
                e.data = exp_v;
                e.cyc  = cyc + 3;
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", sbq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_r_en"}, r_en, 0);
        check({tag, "_r_addr"}, r_addr, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint s;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        bias     = '0;
        for (int i = 0; i < (1<<addr_size); i++) wrom[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check_idle("reset");
        @(negedge clk);

        // 1.0 x 0.5 four times, no bias
        vd = '{256, 256, 256, 256};
        vw = '{128, 128, 128, 128};
        send_vec(4, 0, 512, 0);
        drain();

        // negative sum clipped by ReLU
        vw = '{-128, -128, -128, -128};
        send_vec(4, 256, 0, 0);
        drain();

        // positive saturation
        vd = '{32512, 32512, 32512, 32512};
        vw = '{32512, 32512, 32512, 32512};
        send_vec(4, 0, 32767, 0);
        drain();

        // bias only, back-to-back then gapped
        vd = '{0, 0, 0, 0};
        vw = '{128, -77, 900, 5};
        send_vec(4, 384, 384, 0);
        drain();
        send_vec(4, 384, 384, 3);
        drain();

        // two vectors, second starts in the OUT cycle of the first
        vd = '{256, 256, 256, 256};
        vw = '{128, 128, 128, 128};
        send_vec(4, 0, 512, 0);
        vw = '{256, 256, 256, 256};
        send_vec(4, 0, 1024, 0);
        drain();

        // random vectors against a reference model
        for (int k = 0; k < 4; k++) begin
            int b;
            s = 0;
            for (int i = 0; i < 4; i++) begin
                vd[i] = int'($urandom_range(0, 4000)) - 2000;
                vw[i] = int'($urandom_range(0, 4000)) - 2000;
                s += longint'(vd[i]) * longint'(vw[i]);
            end
            b = int'($urandom_range(0, 8000)) - 2000;
            s += longint'(b) * 256;
            send_vec(4, b, act_model(s), k % 2);
            drain();
        end

        // known nonzero out_data before the abort
        vd = '{256, 256, 256, 256};
        vw = '{256, 256, 256, 256};
        send_vec(4, 0, 1024, 0);
        drain();

        // abort after two accepts, read attempted in the reset cycle
        vw = '{128, 128, 128, 128};
        send_vec(2, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'd30000;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1 check_idle("abort");
        @(negedge clk);
        send_vec(4, 0, 512, 0);
        drain();
        repeat (8) @(negedge clk);
        check("queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
